dds_phase_osc: RTL and testbench

Phase-accumulator oscillator that consumes the 32-bit `ADDER` phase increment produced by the note/pitch-to-DDS converter and turns it into audio samples. Every clock it adds the increment to a 32-bit phase accumulator. At a fixed sample rate it derives one of four waveforms from the accumulator and emits it with a one-cycle valid strobe. It sits between the note/pitch front end and the envelope/mixer stages of each voice.

---
 rtl/dds_phase_osc.sv | 95 +++++++++
 tb/tb_dds_phase_osc.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/dds_phase_osc.sv
`default_nettype none
// ============================================================================
// Module   : dds_phase_osc
// Brief    : 32-bit phase-accumulator oscillator. Steps the phase every clock,
//            emits saw/square/triangle/pulse samples at a fixed sample rate
//            with a one-cycle valid strobe, and flags accumulator wrap for
//            hard sync of other voices.
// Revision : 1.0 - initial release
// ============================================================================
module dds_phase_osc #(
  parameter int OUT_WIDTH  = 16,
  parameter int SAMPLE_DIV = 2048,
  parameter int RETRIG     = 1
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic [31:0]                 ADDER,
  input  logic                        GATE,
  input  logic [1:0]                  WAVE,
  input  logic [7:0]                  PW,
  output logic signed [OUT_WIDTH-1:0] SAMPLE,
  output logic                        SAMPLE_VALID,
  output logic                        WRAP
);

  localparam int                CNT_W    = $clog2(SAMPLE_DIV);
  localparam logic [CNT_W-1:0]  DIV_LAST = CNT_W'(SAMPLE_DIV - 1);
  localparam logic [OUT_WIDTH-1:0] POS_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] NEG_MAX = {1'b1, {(OUT_WIDTH-2){1'b0}}, 1'b1};

  logic [31:0]          inc_r;
  logic [31:0]          acc;
  logic                 gate_d;
  logic [CNT_W-1:0]     div_cnt;
  logic [32:0]          sum;
  logic                 retrig;
  logic [OUT_WIDTH-1:0] tri_val;
  logic [OUT_WIDTH-1:0] wave_val;

  // Phase step with carry, and the gate rising-edge restart condition.
  always_comb begin
    sum    = {1'b0, acc} + {1'b0, inc_r};
    retrig = (RETRIG != 0) && GATE && !gate_d;
  end

  // Waveform shaping from the current (pre-update) accumulator value.
  always_comb begin
    tri_val  = acc[31] ? ~acc[30:31-OUT_WIDTH] : acc[30:31-OUT_WIDTH];
    wave_val = '0;
    case (WAVE)
      2'd0:    wave_val = {~acc[31], acc[30:32-OUT_WIDTH]};
      2'd1:    wave_val = acc[31] ? NEG_MAX : POS_MAX;
      2'd2:    wave_val = {~tri_val[OUT_WIDTH-1], tri_val[OUT_WIDTH-2:0]};
      default: wave_val = (acc[31:24] < PW) ? POS_MAX : NEG_MAX;
    endcase
  end

  // Phase accumulator: restart on gate edge (wins over carry), else step.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      inc_r  <= '0;
      acc    <= '0;
      gate_d <= 1'b0;
      WRAP   <= 1'b0;
    end else begin
      inc_r  <= ADDER;
      gate_d <= GATE;
      if (retrig) begin
        acc  <= '0;
        WRAP <= 1'b0;
      end else begin
        acc  <= sum[31:0];
        WRAP <= sum[32];
      end
    end
  end

  // Sample-rate divider; latches a new sample once per period.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      div_cnt      <= '0;
      SAMPLE       <= '0;
      SAMPLE_VALID <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt      <= '0;
      SAMPLE       <= wave_val;
      SAMPLE_VALID <= 1'b1;
    end else begin
      div_cnt      <= div_cnt + 1'b1;
      SAMPLE_VALID <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dds_phase_osc.sv
`default_nettype none
// ============================================================================
// Module   : tb_dds_phase_osc
// Brief    : Scoreboard bench for dds_phase_osc. Two instances share stimulus:
//            one with restart-on-gate and a divide of 4, one free-running with
//            a divide of 2. A phase/waveform reference model queues expected
//            samples; a monitor pops them on each valid strobe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dds_phase_osc;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adder;
  logic        gate;
  logic [1:0]  wave;
  logic [7:0]  pw;
  logic [15:0] s0, s1;
  logic        v0, v1, w0, w1;

  always #5 clk = ~clk;

  dds_phase_osc #(.OUT_WIDTH(16), .SAMPLE_DIV(4), .RETRIG(1)) dut0 (
    .CLK(clk), .RESET(rst), .ADDER(adder), .GATE(gate), .WAVE(wave), .PW(pw),
    .SAMPLE(s0), .SAMPLE_VALID(v0), .WRAP(w0));

  dds_phase_osc #(.OUT_WIDTH(16), .SAMPLE_DIV(2), .RETRIG(0)) dut1 (
    .CLK(clk), .RESET(rst), .ADDER(adder), .GATE(gate), .WAVE(wave), .PW(pw),
    .SAMPLE(s1), .SAMPLE_VALID(v1), .WRAP(w1));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Ideal waveform value for a 32-bit phase, computed arithmetically.
  function automatic logic [15:0] wave_ref(input longint ph, input logic [1:0] ws,
                                           input logic [7:0] p);
    int     v;
    longint lvl;
    case (ws)
      2'd0: v = int'(ph >> 16) - 32768;
      2'd1: v = (ph < 64'h8000_0000) ? 32767 : -32767;
      2'd2: begin
        lvl = (ph < 64'h8000_0000) ? (ph >> 15) : ((64'hFFFF_FFFF - ph) >> 15);
        v   = int'(lvl) - 32768;
      end
      default: v = ((ph >> 24) < longint'(p)) ? 32767 : -32767;
    endcase
    return v[15:0];
  endfunction

  // Reference model state, one slot per instance.
  longint      m_acc[2];
  longint      m_inc[2];
  bit          m_gd[2];
  int          m_cnt[2];
  bit          m_wrap[2];
  bit          m_valid[2];
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  bit          first0 = 1'b0;

  // Model: advance the phase and queue an expected sample on strobe cycles.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      longint sum;
      int     div;
      bit     rt;
      div = (k == 0) ? 4 : 2;
      rt  = (k == 0);
      if (rst) begin
        m_acc[k] = 0; m_inc[k] = 0; m_gd[k] = 0; m_cnt[k] = 0;
        m_wrap[k] = 0; m_valid[k] = 0;
        if (k == 0) q0.delete(); else q1.delete();
      end else begin
        sum        = m_acc[k] + m_inc[k];
        m_valid[k] = (m_cnt[k] == div - 1);
        if (m_valid[k]) begin
          if (k == 0) q0.push_back(wave_ref(m_acc[k], wave, pw));
          else        q1.push_back(wave_ref(m_acc[k], wave, pw));
        end
        if (rt && gate && !m_gd[k]) begin
          m_acc[k]  = 0;
          m_wrap[k] = 0;
        end else begin
          m_acc[k]  = sum % 64'h1_0000_0000;
          m_wrap[k] = (sum >= 64'h1_0000_0000);
        end
        m_cnt[k] = (m_cnt[k] + 1) % div;
        m_inc[k] = adder;
        m_gd[k]  = gate;
      end
    end
  end

  // Monitor: compare strobes, samples, wrap and phase shortly after each edge.
  always @(posedge clk) begin
    logic [15:0] e;
    #1;
    check("wrap0", w0, m_wrap[0]);
    check("wrap1", w1, m_wrap[1]);
    check("acc0", dut0.acc, m_acc[0]);
    check("acc1", dut1.acc, m_acc[1]);
    check("valid0", v0, m_valid[0]);
    check("valid1", v1, m_valid[1]);
    if (rst) begin
      check("rst_sample0", s0, 0);
      check("rst_sample1", s1, 0);
    end
    if (v0 && q0.size() > 0) begin
      e = q0.pop_front();
      check("sample0", s0, e);
      if (first0) begin
        check("first_saw_sample", s0, 16'hA000);
        first0 = 1'b0;
      end
    end else if (v0) check("sample0_unexpected", 1, 0);
    else if (q0.size() > 0) void'(q0.pop_front());
    if (v1 && q1.size() > 0) begin
      e = q1.pop_front();
      check("sample1", s1, e);
    end else if (v1) check("sample1_unexpected", 1, 0);
    else if (q1.size() > 0) void'(q1.pop_front());
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; adder = 32'hFFFF_FFFF; gate = 1'b0; wave = 2'd0; pw = 8'd0;
    // Reset held across three edges while inputs are busy.
    repeat (3) @(negedge clk) gate = ~gate;
    adder = 32'h1000_0000; gate = 1'b0; first0 = 1'b1; rst = 1'b0;
    cycles(64);                       // saw, wrap every 16 cycles
    wave = 2'd1; cycles(64);          // square
    wave = 2'd3; pw = 8'h40; cycles(64);
    pw = 8'h00; cycles(32);           // pulse width 0
    wave = 2'd2; adder = 32'h0100_0000; cycles(600); // triangle

    // Increment latency and zero-increment freeze.
    rst = 1'b1; adder = 32'd0; cycles(1);
    rst = 1'b0; cycles(3);
    adder = 32'd5;
    @(posedge clk); #2;
    check("lat_edge_n", dut0.acc, 0);
    @(posedge clk); #2;
    check("lat_edge_n1", dut0.acc, 5);
    @(posedge clk); #2;
    check("lat_edge_n2", dut0.acc, 10);
    cycles(1);

    // Large increments with a busy gate: carries collide with gate edges.
    adder = 32'hC000_0001;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      gate = 1'($urandom_range(0, 1));
    end

    // Fully random phase including occasional mid-period reset.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      gate = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0)
        adder = ($urandom_range(0, 1) == 1) ? $urandom : ($urandom >> $urandom_range(4, 28));
      if ($urandom_range(0, 7) == 0) wave = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) pw = 8'($urandom);
      rst = ($urandom_range(0, 299) == 0);
    end
    rst = 1'b0;
    cycles(8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
